box_motion_sequencer: RTL and testbench



---
 rtl/box_motion_sequencer_pkg.sv | 35 +++
 rtl/box_motion_sequencer_if.sv | 31 +++
 rtl/box_motion_sequencer_axis_step.sv | 46 ++++
 rtl/box_motion_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_box_motion_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_motion_sequencer_pkg.sv
// Shared constants, types and helpers for the bouncing-box screensaver.
// Screen and box geometry, velocity width, position widths, the motion
// FSM state type and the colour-advance rule live here.
package screensaver_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BOX_WIDTH     = 100;
  localparam int BOX_HEIGHT    = 100;
  localparam int VW            = 4;

  localparam int X_W     = $clog2(SCREEN_WIDTH);
  localparam int Y_W     = $clog2(SCREEN_HEIGHT);
  localparam int POS_W   = (X_W > Y_W) ? X_W : Y_W;
  localparam int COLOR_W = 3;

  // Largest legal left/top edge; reaching it counts as an edge hit.
  localparam int X_LIMIT = SCREEN_WIDTH - BOX_WIDTH;
  localparam int Y_LIMIT = SCREEN_HEIGHT - BOX_HEIGHT;

  localparam logic [COLOR_W-1:0] COLOR_INIT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_X = 2'd1,
    ST_CALC_Y = 2'd2,
    ST_COMMIT = 2'd3
  } motion_state_t;

  // Colour cycles 1..7 and skips black (0).
  function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] c);
    return (c == COLOR_INIT) ? COLOR_W'(1) : c + COLOR_W'(1);
  endfunction

endpackage

// File: rtl/box_motion_sequencer_if.sv
// Bus between the video timer / image stage and the motion sequencer.
//   frame  : frame counter from the video timer (any change = new frame)
//   vblank : high outside the visible frame
//   pause  : freezes motion, frames are ignored
//   box_x, box_y, color : committed box position and colour {b,g,r}
//   busy   : sequencer is mid-update
//   bounce : one-cycle pulse at commit when an edge was hit
// master = timing/image side, slave = sequencer.
interface box_motion_sequencer_if;
  import screensaver_pkg::*;

  logic [31:0]        frame;
  logic               vblank;
  logic               pause;
  logic [X_W-1:0]     box_x;
  logic [Y_W-1:0]     box_y;
  logic [COLOR_W-1:0] color;
  logic               busy;
  logic               bounce;

  modport master (
    output frame, vblank, pause,
    input  box_x, box_y, color, busy, bounce
  );

  modport slave (
    input  frame, vblank, pause,
    output box_x, box_y, color, busy, bounce
  );

endinterface

// File: rtl/box_motion_sequencer_axis_step.sv
// One axis of box motion for one frame: add velocity to position, detect an
// edge hit, clamp the position into [0, limit] and reflect the velocity on a
// hit. Purely combinational; the sequencer time-shares a single instance
// between X and Y, which is why the limit arrives as an input.
// Ports:
//   pos      : current position (unsigned)
//   limit    : largest legal position for this axis
//   vel      : signed velocity
//   pos_next : clamped new position
//   vel_next : velocity, negated on a hit
//   hit      : new position fell below 0 or reached/passed limit
module axis_step #(
  parameter int PW = 10,
  parameter int VW = 4
) (
  input  logic [PW-1:0]        pos,
  input  logic [PW-1:0]        limit,
  input  logic signed [VW-1:0] vel,
  output logic [PW-1:0]        pos_next,
  output logic signed [VW-1:0] vel_next,
  output logic                 hit
);

  // Two extra bits: one for the sign, one for overflow past the top of pos.
  logic signed [PW+1:0] sum;
  logic signed [PW+1:0] lim_s;
  logic                 below;
  logic                 above;

  always_comb begin
    sum      = $signed({2'b00, pos}) + $signed({{(PW+2-VW){vel[VW-1]}}, vel});
    lim_s    = $signed({2'b00, limit});
    below    = sum < 0;
    above    = sum >= lim_s;
    hit      = below | above;
    if (below) begin
      pos_next = '0;
    end else if (above) begin
      pos_next = limit;
    end else begin
      pos_next = sum[PW-1:0];
    end
    vel_next = hit ? -vel : vel;
  end

endmodule

// File: rtl/box_motion_sequencer.sv
// Per-frame motion controller for the bouncing box. A change on the frame
// counter raises a pending request; the update runs from IDLE once vblank is
// high and pause is low, stepping X, then Y, through one shared axis_step,
// and finally commits position, velocity and colour in a single edge so the
// image stage never sees a half-updated box.
// Ports:
//   clk : pixel clock
//   rst : synchronous, active-high reset
//   bus : slave side of box_motion_sequencer_if (frame/vblank/pause in,
//         box_x/box_y/color/busy/bounce out)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for pending && vblank && !pause
// ST_CALC_X | X step through the shared adder, result staged
// ST_CALC_Y | Y step through the shared adder, bounce decided
// ST_COMMIT | staged values become visible, colour advances on a hit
module box_motion_sequencer
  import screensaver_pkg::*;
#(
  parameter int INIT_X  = 50,
  parameter int INIT_Y  = 50,
  parameter int INIT_XV = 2,
  parameter int INIT_YV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  box_motion_sequencer_if.slave bus
);

  motion_state_t        state_q, state_d;
  logic [31:0]          frame_prev_q, frame_prev_d;
  logic                 pending_q, pending_d;
  logic [X_W-1:0]       box_x_q, box_x_d;
  logic [Y_W-1:0]       box_y_q, box_y_d;
  logic signed [VW-1:0] xv_q, xv_d;
  logic signed [VW-1:0] yv_q, yv_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 busy_q, busy_d;
  logic                 bounce_q, bounce_d;
  logic [X_W-1:0]       stg_x_q, stg_x_d;
  logic signed [VW-1:0] stg_xv_q, stg_xv_d;
  logic                 hx_q, hx_d;
  logic [Y_W-1:0]       stg_y_q, stg_y_d;
  logic signed [VW-1:0] stg_yv_q, stg_yv_d;

  logic                 frame_new;
  logic                 start;

  logic [POS_W-1:0]     step_pos;
  logic [POS_W-1:0]     step_limit;
  logic signed [VW-1:0] step_vel;
  logic [POS_W-1:0]     step_pos_next;
  logic signed [VW-1:0] step_vel_next;
  logic                 step_hit;

  // Operand mux for the shared adder: X in CALC_X, Y otherwise.
  always_comb begin
    if (state_q == ST_CALC_X) begin
      step_pos   = POS_W'(box_x_q);
      step_vel   = xv_q;
      step_limit = POS_W'(X_LIMIT);
    end else begin
      step_pos   = POS_W'(box_y_q);
      step_vel   = yv_q;
      step_limit = POS_W'(Y_LIMIT);
    end
  end

  axis_step #(
    .PW (POS_W),
    .VW (VW)
  ) u_axis_step (
    .pos      (step_pos),
    .limit    (step_limit),
    .vel      (step_vel),
    .pos_next (step_pos_next),
    .vel_next (step_vel_next),
    .hit      (step_hit)
  );

  always_comb begin
    state_d      = state_q;
    frame_prev_d = bus.frame;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    xv_d         = xv_q;
    yv_d         = yv_q;
    color_d      = color_q;
    busy_d       = busy_q;
    bounce_d     = 1'b0;
    stg_x_d      = stg_x_q;
    stg_xv_d     = stg_xv_q;
    hx_d         = hx_q;
    stg_y_d      = stg_y_q;
    stg_yv_d     = stg_yv_q;

    frame_new = bus.frame != frame_prev_q;
    start     = (state_q == ST_IDLE) && pending_q && bus.vblank && !bus.pause;

    // A frame landing on the start cycle is a genuinely new request and
    // stays pending; older ones are absorbed by the update being started.
    if (bus.pause) begin
      pending_d = 1'b0;
    end else if (start) begin
      pending_d = frame_new;
    end else begin
      pending_d = pending_q | frame_new;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC_X;
          busy_d  = 1'b1;
        end
      end
      ST_CALC_X: begin
        stg_x_d  = step_pos_next[X_W-1:0];
        stg_xv_d = step_vel_next;
        hx_d     = step_hit;
        state_d  = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        stg_y_d  = step_pos_next[Y_W-1:0];
        stg_yv_d = step_vel_next;
        // Registered here so the pulse lines up with the COMMIT cycle.
        bounce_d = hx_q | step_hit;
        state_d  = ST_COMMIT;
      end
      ST_COMMIT: begin
        box_x_d = stg_x_q;
        box_y_d = stg_y_q;
        xv_d    = stg_xv_q;
        yv_d    = stg_yv_q;
        if (bounce_q) begin
          color_d = next_color(color_q);
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_prev_q <= bus.frame;
      pending_q    <= 1'b0;
      box_x_q      <= X_W'(INIT_X);
      box_y_q      <= Y_W'(INIT_Y);
      xv_q         <= VW'(INIT_XV);
      yv_q         <= VW'(INIT_YV);
      color_q      <= COLOR_INIT;
      busy_q       <= 1'b0;
      bounce_q     <= 1'b0;
      stg_x_q      <= '0;
      stg_xv_q     <= '0;
      hx_q         <= 1'b0;
      stg_y_q      <= '0;
      stg_yv_q     <= '0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_prev_d;
      pending_q    <= pending_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      xv_q         <= xv_d;
      yv_q         <= yv_d;
      color_q      <= color_d;
      busy_q       <= busy_d;
      bounce_q     <= bounce_d;
      stg_x_q      <= stg_x_d;
      stg_xv_q     <= stg_xv_d;
      hx_q         <= hx_d;
      stg_y_q      <= stg_y_d;
      stg_yv_q     <= stg_yv_d;
    end
  end

  assign bus.box_x  = box_x_q;
  assign bus.box_y  = box_y_q;
  assign bus.color  = color_q;
  assign bus.busy   = busy_q;
  assign bus.bounce = bounce_q;

endmodule

// File: tb/tb_box_motion_sequencer.sv
// Directed bench for box_motion_sequencer. Three instances with different
// start positions share one set of frame/vblank/pause inputs; sel picks the
// instance being scored. Expected commits are pushed by a behavioural model
// when a serviced frame is driven and popped by the monitor when the DUT's
// busy window closes.
module tb_box_motion_sequencer;
  import screensaver_pkg::*;

  typedef struct {
    int x;
    int y;
    int c;
    int b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] frame_r;
  logic        vblank_r;
  logic        pause_r;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel = 0;
  bit mon_en = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // model state
  int mx, my, mxv, myv, mc;

  // monitor state
  bit               busy_prev;
  int               run_len, bounce_run, commits, commit_cyc, busy_cycles;
  logic [X_W-1:0]   prev_x;
  logic [Y_W-1:0]   prev_y;
  logic [COLOR_W-1:0] prev_c;
  bit               commit_now;

  int c0, cf, cv, bc0;

  box_motion_sequencer_if bif0 ();
  box_motion_sequencer_if bif3 ();
  box_motion_sequencer_if bif4 ();

  assign bif0.frame = frame_r;  assign bif0.vblank = vblank_r;  assign bif0.pause = pause_r;
  assign bif3.frame = frame_r;  assign bif3.vblank = vblank_r;  assign bif3.pause = pause_r;
  assign bif4.frame = frame_r;  assign bif4.vblank = vblank_r;  assign bif4.pause = pause_r;

  box_motion_sequencer u_dut0 (.clk(clk), .rst(rst), .bus(bif0));
  box_motion_sequencer #(.INIT_X(538), .INIT_XV(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bif3));
  box_motion_sequencer #(.INIT_X(1), .INIT_XV(-2), .INIT_Y(379), .INIT_YV(1))
    u_dut4 (.clk(clk), .rst(rst), .bus(bif4));

  logic [X_W-1:0]     obs_x;
  logic [Y_W-1:0]     obs_y;
  logic [COLOR_W-1:0] obs_c;
  logic               obs_busy;
  logic               obs_bounce;

  always_comb begin
    obs_x = bif0.box_x; obs_y = bif0.box_y; obs_c = bif0.color;
    obs_busy = bif0.busy; obs_bounce = bif0.bounce;
    case (sel)
      3: begin
        obs_x = bif3.box_x; obs_y = bif3.box_y; obs_c = bif3.color;
        obs_busy = bif3.busy; obs_bounce = bif3.bounce;
      end
      4: begin
        obs_x = bif4.box_x; obs_y = bif4.box_y; obs_c = bif4.color;
        obs_busy = bif4.busy; obs_bounce = bif4.bounce;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Monitor: a busy window closing marks a commit.
  always @(negedge clk) begin
    if (!mon_en) begin
      busy_prev  = 1'b0;
      run_len    = 0;
      bounce_run = 0;
    end else begin
      if (obs_busy) begin
        run_len++;
        busy_cycles++;
        if (obs_bounce) bounce_run++;
      end
      commit_now = busy_prev && !obs_busy;
      if (obs_x != prev_x || obs_y != prev_y || obs_c != prev_c)
        check("outputs_change_only_at_commit", commit_now, 1);
      if (commit_now) begin
        commits++;
        commit_cyc = cyc;
        check("commit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("box_x", obs_x, mon_e.x);
          check("box_y", obs_y, mon_e.y);
          check("color", obs_c, mon_e.c);
          check("bounce_pulses", bounce_run, mon_e.b);
          check("busy_len", run_len, 3);
        end
        run_len    = 0;
        bounce_run = 0;
      end
      busy_prev = obs_busy;
    end
    prev_x = obs_x;
    prev_y = obs_y;
    prev_c = obs_c;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init(input int x, input int xv, input int y, input int yv);
    mx = x; mxv = xv; my = y; myv = yv; mc = 7;
  endtask

  task automatic model_axis(inout int p, inout int v, input int lim, output bit hit);
    int t;
    t = p + v;
    hit = (t < 0) || (t >= lim);
    p = (t < 0) ? 0 : ((t > lim) ? lim : t);
    if (hit) v = -v;
  endtask

  task automatic model_frame();
    bit hx, hy;
    exp_t e;
    model_axis(mx, mxv, SCREEN_WIDTH - BOX_WIDTH, hx);
    model_axis(my, myv, SCREEN_HEIGHT - BOX_HEIGHT, hy);
    if (hx || hy) mc = (mc == 7) ? 1 : mc + 1;
    e.x = mx; e.y = my; e.c = mc; e.b = (hx || hy) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    step();
    mon_en = 1;
  endtask

  initial begin
    rst = 1'b1; frame_r = 32'd0; vblank_r = 1'b0; pause_r = 1'b0;
    commits = 0; busy_cycles = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    mon_en = 1;
    model_init(50, 2, 50, 1);

    // 1: constant frame, vblank high: nothing happens
    vblank_r = 1'b1;
    c0 = commits;
    repeat (20) step();
    check("t1_box_x", obs_x, 50);
    check("t1_box_y", obs_y, 50);
    check("t1_color", obs_c, 7);
    check("t1_busy", obs_busy, 0);
    check("t1_bounce", obs_bounce, 0);
    check("t1_no_commit", commits - c0, 0);
    check("t1_no_busy", busy_cycles, 0);

    // 2: single frame, plain move
    frame_r = frame_r + 1;
    cf = cyc;
    model_frame();
    drain("t2");
    check("t2_latency", commit_cyc - cf, 5);
    check("t2_box_x_after", obs_x, 52);
    check("t2_box_y_after", obs_y, 51);

    // 3: right-edge hit then move back
    sel = 3;
    do_reset();
    model_init(538, 2, 50, 1);
    check("t3_reset_x", obs_x, 538);
    frame_r = frame_r + 1;
    model_frame();
    drain("t3a");
    check("t3_color_after_hit", obs_c, 1);
    frame_r = frame_r + 1;
    model_frame();
    drain("t3b");
    check("t3_box_x_back", obs_x, 538);

    // 4: corner hit, single colour advance
    sel = 4;
    do_reset();
    model_init(1, -2, 379, 1);
    frame_r = frame_r + 1;
    model_frame();
    drain("t4a");
    check("t4_box_x", obs_x, 0);
    check("t4_box_y", obs_y, 380);
    frame_r = frame_r + 1;
    model_frame();
    drain("t4b");

    // 5: wait for vblank, then pause suppression
    sel = 0;
    do_reset();
    model_init(50, 2, 50, 1);
    vblank_r = 1'b0;
    c0 = commits;
    bc0 = busy_cycles;
    frame_r = frame_r + 1;
    repeat (100) step();
    check("t5_no_commit_outside_vblank", commits - c0, 0);
    check("t5_no_busy_outside_vblank", busy_cycles - bc0, 0);
    model_frame();
    vblank_r = 1'b1;
    cv = cyc;
    drain("t5");
    check("t5_commit_delay", commit_cyc - cv, 4);
    repeat (10) step();
    check("t5_single_commit", commits - c0, 1);
    bc0 = busy_cycles;
    pause_r = 1'b1;
    frame_r = frame_r + 1;
    repeat (3) step();
    frame_r = frame_r + 1;
    repeat (3) step();
    pause_r = 1'b0;
    repeat (20) step();
    check("t5_no_commit_after_pause", commits - c0, 1);
    check("t5_no_busy_after_pause", busy_cycles - bc0, 0);

    // 6: reset during CALC_Y
    frame_r = frame_r + 1;
    repeat (3) step();
    check("t6_busy_in_calc_y", obs_busy, 1);
    mon_en = 0;
    rst = 1'b1;
    step();
    check("t6_busy_after_rst", obs_busy, 0);
    check("t6_box_x_after_rst", obs_x, 50);
    check("t6_box_y_after_rst", obs_y, 50);
    check("t6_color_after_rst", obs_c, 7);
    check("t6_bounce_after_rst", obs_bounce, 0);
    rst = 1'b0;
    step();
    mon_en = 1;
    model_init(50, 2, 50, 1);
    frame_r = frame_r + 1;
    cf = cyc;
    model_frame();
    drain("t6");
    check("t6_latency", commit_cyc - cf, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
